pciecfg_mgmt_arbiter: RTL

Shares the single PCIe core configuration-management port (`cfg_mgmt_*`) between `NREQ` independent requesters, e.g. the network-driven config-access engine and a local init sequencer. It accepts one read or write command at a time under round-robin arbitration and holds the enable strobe until the core reports completion. It returns read data and a completion pulse to the winner, and aborts with an error response if the core does not answer within a bounded time.

---
 rtl/pciecfg_mgmt_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pciecfg_mgmt_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pciecfg_mgmt_arbiter
// Brief   : Round-robin sharing of the PCIe core cfg_mgmt port between NREQ
//           requesters, with completion/timeout responses.
// Revision: 1.0 - initial release
// ============================================================================
module pciecfg_mgmt_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*10-1:0]   req_dwaddr,
    input  logic [NREQ*4-1:0]    req_byte_en,
    input  logic [NREQ*32-1:0]   req_di,

    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 rsp_timeout,

    output logic [9:0]           cfg_mgmt_dwaddr,
    output logic                 cfg_mgmt_rd_en,
    output logic                 cfg_mgmt_wr_en,
    output logic [3:0]           cfg_mgmt_byte_en,
    output logic [31:0]          cfg_mgmt_di,
    input  logic [31:0]          cfg_mgmt_do,
    input  logic                 cfg_mgmt_rd_wr_done
);

    localparam int c_GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    localparam logic [c_CW-1:0] c_TO_MAX    = c_CW'(TIMEOUT);
    localparam logic [c_GW-1:0] c_LAST_INIT = c_GW'(NREQ - 1);

    logic [1:0]      r_state;
    logic [c_GW-1:0] r_last_grant;
    logic [c_GW-1:0] r_cmd_idx;
    logic            r_we;
    logic [9:0]      r_dwaddr;
    logic [3:0]      r_byte_en;
    logic [31:0]     r_di;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_timeout;

    logic [c_GW-1:0] w_grant;
    logic            w_found;
    logic            w_hs;

    // Search upward from the requester after the last winner, wrapping once.
    always_comb begin : grant_search
        int idx;
        idx     = 0;
        w_grant = r_last_grant;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_grant = c_GW'(idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_hs      = (r_state == c_IDLE) && w_found && !rst;
    assign req_ready = w_hs ? (NREQ'(1) << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_last_grant  <= c_LAST_INIT;
            r_cmd_idx     <= '0;
            r_we          <= 1'b0;
            r_dwaddr      <= '0;
            r_byte_en     <= '0;
            r_di          <= '0;
            r_cnt         <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_we         <= req_we[w_grant];
                        r_dwaddr     <= req_dwaddr[int'(w_grant)*10 +: 10];
                        r_byte_en    <= req_we[w_grant] ? req_byte_en[int'(w_grant)*4 +: 4] : 4'h0;
                        r_di         <= req_di[int'(w_grant)*32 +: 32];
                        r_cmd_idx    <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    // A completion in the final counted cycle takes priority over the abort.
                    if (cfg_mgmt_rd_wr_done) begin
                        r_rsp_data    <= r_we ? 32'h0 : cfg_mgmt_do;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= c_RESP;
                    end else if (r_cnt == c_TO_MAX) begin
                        r_rsp_data    <= 32'hFFFF_FFFF;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_RESP: begin
                    r_state <= c_GAP;
                end
                c_GAP: begin
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid        = (r_state == c_RESP) ? (NREQ'(1) << r_cmd_idx) : '0;
    assign rsp_data         = r_rsp_data;
    assign rsp_timeout      = r_rsp_timeout;

    assign cfg_mgmt_rd_en   = (r_state == c_ISSUE) && !r_we;
    assign cfg_mgmt_wr_en   = (r_state == c_ISSUE) &&  r_we;
    assign cfg_mgmt_dwaddr  = r_dwaddr;
    assign cfg_mgmt_byte_en = r_byte_en;
    assign cfg_mgmt_di      = r_di;

endmodule
`default_nettype wire
